// File: rtl/rs_ldst_issue_if.sv
// Issue-port bundle between the LDST reservation station/dispatch side and the
// in-order issue controller.
interface rs_ldst_issue_if #(
    parameter int ENT_NUM = 4,
    parameter int ENT_SEL = 2
);
    logic               we1;
    logic [ENT_SEL-1:0] waddr1;
    logic               we2;
    logic [ENT_SEL-1:0] waddr2;
    logic [ENT_NUM-1:0] busyvec;
    logic [ENT_NUM-1:0] ready;
    logic               prmiss;
    logic               prsuccess;
    logic [ENT_NUM-1:0] prbusyvec_next;
    logic               mem_stall;
    logic               clearbusy;
    logic [ENT_SEL-1:0] issueaddr;
    logic               ex_valid;
    logic [ENT_SEL-1:0] ex_addr;
    logic [ENT_SEL:0]   qcount;
    logic               ord_err;

    modport master (
        output we1, waddr1, we2, waddr2, busyvec, ready, prmiss, prsuccess,
               prbusyvec_next, mem_stall,
        input  clearbusy, issueaddr, ex_valid, ex_addr, qcount, ord_err
    );

    modport slave (
        input  we1, waddr1, we2, waddr2, busyvec, ready, prmiss, prsuccess,
               prbusyvec_next, mem_stall,
        output clearbusy, issueaddr, ex_valid, ex_addr, qcount, ord_err
    );
endinterface

// File: rtl/rs_ldst_issue.sv
// In-order issue controller for the LDST reservation station: age queue of entry
// indices, head-only issue, one-stage launch register, mispredict compaction.
module rs_ldst_issue #(
    parameter int ENT_NUM = 4,
    parameter int ENT_SEL = 2
) (
    input  logic             clk,
    input  logic             reset,
    rs_ldst_issue_if.slave   bus
);
    localparam logic [ENT_SEL:0] CNT_MAX = (ENT_SEL+1)'(ENT_NUM);
    localparam logic [ENT_SEL:0] CNT_ONE = (ENT_SEL+1)'(1);

    logic [ENT_SEL-1:0] ord_reg   [ENT_NUM];
    logic [ENT_SEL-1:0] ord_next  [ENT_NUM];
    logic [ENT_SEL-1:0] shift_ord [ENT_NUM];
    logic [ENT_SEL:0]   cnt_reg, cnt_next;
    logic               ex_valid_reg;
    logic [ENT_SEL-1:0] ex_addr_reg;
    logic               ord_err_reg, ord_err_next;
    logic [ENT_SEL-1:0] head;
    logic               clearbusy;
    logic [ENT_SEL:0]   fill;
    logic [ENT_SEL:0]   keep;

    assign head      = ord_reg[0];
    assign clearbusy = (cnt_reg != '0) & bus.ready[head] & ~bus.mem_stall & ~bus.prmiss;

    // Queue as it looks after the head leaves; the top slot refills with zero.
    genvar gi;
    generate
        for (gi = 0; gi < ENT_NUM; gi++) begin : g_shift
            if (gi < ENT_NUM - 1) begin : g_mid
                assign shift_ord[gi] = ord_reg[gi+1];
            end else begin : g_top
                assign shift_ord[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        ord_next     = ord_reg;
        cnt_next     = cnt_reg;
        ord_err_next = ord_err_reg;
        fill         = cnt_reg;
        keep         = '0;

        // A live head must still be busy in the station.
        if ((cnt_reg != '0) && !bus.busyvec[head] && !bus.prmiss)
            ord_err_next = 1'b1;

        if (bus.prmiss) begin
            for (int i = 0; i < ENT_NUM; i++)
                ord_next[i] = '0;
            for (int i = 0; i < ENT_NUM; i++) begin
                if (((ENT_SEL+1)'(i) < cnt_reg) && bus.prbusyvec_next[ord_reg[i]]) begin
                    ord_next[keep[ENT_SEL-1:0]] = ord_reg[i];
                    keep = keep + CNT_ONE;
                end
            end
            cnt_next = keep;
        end else begin
            if (clearbusy) begin
                ord_next = shift_ord;
                fill     = cnt_reg - CNT_ONE;
            end
            // The station sets no busy bits on a resolving-correct cycle.
            if (!bus.prsuccess) begin
                if (bus.we1 && bus.we2 && (bus.waddr1 == bus.waddr2))
                    ord_err_next = 1'b1;
                if (bus.we1) begin
                    if (fill < CNT_MAX) begin
                        ord_next[fill[ENT_SEL-1:0]] = bus.waddr1;
                        fill = fill + CNT_ONE;
                    end else begin
                        ord_err_next = 1'b1;
                    end
                end
                if (bus.we2) begin
                    if (fill < CNT_MAX) begin
                        ord_next[fill[ENT_SEL-1:0]] = bus.waddr2;
                        fill = fill + CNT_ONE;
                    end else begin
                        ord_err_next = 1'b1;
                    end
                end
            end
            cnt_next = fill;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENT_NUM; i++)
                ord_reg[i] <= '0;
            cnt_reg      <= '0;
            ex_valid_reg <= 1'b0;
            ex_addr_reg  <= '0;
            ord_err_reg  <= 1'b0;
        end else begin
            for (int i = 0; i < ENT_NUM; i++)
                ord_reg[i] <= ord_next[i];
            cnt_reg      <= cnt_next;
            ord_err_reg  <= ord_err_next;
            ex_valid_reg <= clearbusy;
            if (clearbusy)
                ex_addr_reg <= head;
        end
    end

    assign bus.clearbusy = clearbusy;
    assign bus.issueaddr = head;
    assign bus.ex_valid  = ex_valid_reg;
    assign bus.ex_addr   = ex_addr_reg;
    assign bus.qcount    = cnt_reg;
    assign bus.ord_err   = ord_err_reg;
endmodule

// File: tb/tb_rs_ldst_issue.sv
// Randomised plus directed bench for rs_ldst_issue with a queue-based reference
// model and a decoupled scoreboard monitor.
module tb_rs_ldst_issue;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rs_ldst_issue_if #(.ENT_NUM(4), .ENT_SEL(2)) bus ();

    rs_ldst_issue #(.ENT_NUM(4), .ENT_SEL(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       cb;
        logic [1:0] ia;
        logic [2:0] qc;
        logic       err;
        logic       exv;
        logic [1:0] exa;
    } exp_t;

    exp_t exp_q[$];
    int   launch_q[$];

    // Reference model: program-order list of allocated entries.
    int m_q[$];
    bit m_err;
    bit m_exv;
    int m_exa;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] mbusy();
        logic [3:0] b;
        b = 4'b0000;
        foreach (m_q[i]) b[m_q[i]] = 1'b1;
        return b;
    endfunction

    task automatic drive_idle();
        bus.we1 = 0; bus.waddr1 = 0; bus.we2 = 0; bus.waddr2 = 0;
        bus.busyvec = 0; bus.ready = 0; bus.prmiss = 0; bus.prsuccess = 0;
        bus.prbusyvec_next = 0; bus.mem_stall = 0;
    endtask

    task automatic step(input bit w1, input int a1, input bit w2, input int a2,
                        input logic [3:0] busy, input logic [3:0] rdy,
                        input bit pm, input bit ps, input logic [3:0] pbv, input bit st);
        exp_t e;
        bit   issue;
        int   keep[$];
        @(negedge clk);
        bus.we1 = w1; bus.waddr1 = 2'(a1); bus.we2 = w2; bus.waddr2 = 2'(a2);
        bus.busyvec = busy; bus.ready = rdy; bus.prmiss = pm; bus.prsuccess = ps;
        bus.prbusyvec_next = pbv; bus.mem_stall = st;

        issue = (m_q.size() != 0) && rdy[m_q[0]] && !st && !pm;
        e.cb  = issue;
        e.ia  = (m_q.size() != 0) ? 2'(m_q[0]) : 2'd0;
        e.qc  = 3'(m_q.size());
        e.err = m_err;
        e.exv = m_exv;
        e.exa = 2'(m_exa);
        exp_q.push_back(e);
        $display("txn t=%0t we1=%0b a1=%0d we2=%0b a2=%0d busy=%b rdy=%b pm=%0b ps=%0b pbv=%b st=%0b exp_cb=%0b exp_q=%0d",
                 $time, w1, a1, w2, a2, busy, rdy, pm, ps, pbv, st, issue, m_q.size());

        if ((m_q.size() != 0) && !busy[m_q[0]] && !pm) m_err = 1;
        if (pm) begin
            foreach (m_q[i]) if (pbv[m_q[i]]) keep.push_back(m_q[i]);
            m_q   = keep;
            m_exv = 0;
        end else begin
            m_exv = issue;
            if (issue) begin
                m_exa = m_q.pop_front();
                launch_q.push_back(m_exa);
            end
            if (!ps) begin
                if (w1 && w2 && (a1 == a2)) m_err = 1;
                if (w1) begin
                    if (m_q.size() < N) m_q.push_back(a1); else m_err = 1;
                end
                if (w2) begin
                    if (m_q.size() < N) m_q.push_back(a2); else m_err = 1;
                end
            end
        end
    endtask

    task automatic do_reset();
        #3;
        reset = 1'b0;
        drive_idle();
        #1;
        check("rst_clearbusy", bus.clearbusy, 0);
        check("rst_ex_valid",  bus.ex_valid, 0);
        check("rst_qcount",    bus.qcount, 0);
        check("rst_ord_err",   bus.ord_err, 0);
        check("rst_issueaddr", bus.issueaddr, 0);
        exp_q.delete();
        launch_q.delete();
        m_q.delete();
        m_err = 0; m_exv = 0; m_exa = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    // Monitor: compares each cycle's expected outputs and every launch.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("clearbusy", bus.clearbusy, e.cb);
                check("issueaddr", bus.issueaddr, e.ia);
                check("qcount",    bus.qcount, e.qc);
                check("ord_err",   bus.ord_err, e.err);
                check("ex_valid",  bus.ex_valid, e.exv);
                check("ex_addr",   bus.ex_addr, e.exa);
            end
            if (bus.ex_valid === 1'b1) begin
                if (launch_q.size() == 0) check("launch_spurious", bus.ex_valid, 0);
                else check("launch_addr", bus.ex_addr, launch_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] busy, rdy, pbv;
        bit         pm, ps, st, w1, w2;
        int         a1, a2;
        int         free[$];
        int         k;

        drive_idle();
        do_reset();

        // Basic issue and launch latency
        step(1, 2, 1, 0, mbusy(), 4'b0000, 0, 0, 4'b0000, 0);
        step(0, 0, 0, 0, mbusy(), 4'b0101, 0, 0, 4'b0000, 0);
        step(0, 0, 0, 0, mbusy(), 4'b0101, 0, 0, 4'b0000, 0);

        // Younger ready entry never bypasses the head
        step(1, 1, 1, 3, mbusy(), 4'b0000, 0, 0, 4'b0000, 0);
        repeat (3) step(0, 0, 0, 0, mbusy(), 4'b1000, 0, 0, 4'b0000, 0);
        step(0, 0, 0, 0, mbusy(), 4'b1010, 0, 0, 4'b0000, 0);
        step(0, 0, 0, 0, mbusy(), 4'b1000, 0, 0, 4'b0000, 0);

        // Mispredict compaction with a concurrent (ignored) allocation
        step(1, 0, 1, 1, mbusy(), 4'b0000, 0, 0, 4'b0000, 0);
        step(1, 2, 1, 3, mbusy(), 4'b0000, 0, 0, 4'b0000, 0);
        step(1, 0, 0, 0, mbusy(), 4'b1111, 1, 0, 4'b1010, 0);
        step(0, 0, 0, 0, mbusy(), mbusy(), 0, 0, 4'b0000, 0);
        step(0, 0, 0, 0, mbusy(), mbusy(), 0, 0, 4'b0000, 0);

        // mem_stall holds off the ready head
        step(1, 2, 0, 0, mbusy(), 4'b0000, 0, 0, 4'b0000, 0);
        repeat (3) step(0, 0, 0, 0, mbusy(), 4'b0100, 0, 0, 4'b0000, 1);
        step(0, 0, 0, 0, mbusy(), 4'b0100, 0, 0, 4'b0000, 0);

        // Full queue: issue frees one slot, then an overflow sets ord_err
        step(1, 3, 1, 2, mbusy(), 4'b0000, 0, 0, 4'b0000, 0);
        step(1, 1, 1, 0, mbusy(), 4'b0000, 0, 0, 4'b0000, 0);
        step(1, 3, 0, 0, mbusy(), 4'b1000, 0, 0, 4'b0000, 0);
        step(1, 3, 0, 0, mbusy(), 4'b0000, 0, 0, 4'b0000, 0);
        step(0, 0, 0, 0, mbusy(), 4'b0000, 0, 0, 4'b0000, 0);
        step(0, 0, 0, 0, mbusy(), 4'b0000, 0, 0, 4'b0000, 0);

        do_reset();

        // Random legal traffic: unique free entries, ready within busy
        for (int n = 0; n < 300; n++) begin
            busy = mbusy();
            rdy  = busy & 4'($urandom);
            pm   = ($urandom % 12) == 0;
            ps   = !pm && (($urandom % 8) == 0);
            pbv  = busy & 4'($urandom);
            st   = ($urandom % 4) == 0;
            free.delete();
            for (int j = 0; j < N; j++) if (!busy[j]) free.push_back(j);
            w1 = 0; w2 = 0; a1 = 0; a2 = 0;
            if ((free.size() != 0) && ($urandom % 2)) begin
                k = $urandom_range(free.size() - 1);
                a1 = free[k]; free.delete(k); w1 = 1;
            end
            if ((free.size() != 0) && ($urandom % 2)) begin
                k = $urandom_range(free.size() - 1);
                a2 = free[k]; free.delete(k); w2 = 1;
            end
            step(w1, a1, w2, a2, busy, rdy, pm, ps, pbv, st);
        end
        step(0, 0, 0, 0, mbusy(), 4'b0000, 0, 0, 4'b0000, 0);
        do_reset();

        // Reset asserted while the head is issuing with three entries queued
        step(1, 0, 1, 1, mbusy(), 4'b0000, 0, 0, 4'b0000, 0);
        step(1, 2, 0, 0, mbusy(), 4'b0000, 0, 0, 4'b0000, 0);
        step(0, 0, 0, 0, mbusy(), mbusy(), 0, 0, 4'b0000, 0);
        do_reset();

        step(0, 0, 0, 0, mbusy(), 4'b0000, 0, 0, 4'b0000, 0);
        step(0, 0, 0, 0, mbusy(), 4'b0000, 0, 0, 4'b0000, 0);
        #3;
        check("launch_drain", launch_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rs_ldst_issue.md
Name: rs_ldst_issue

Overview:
- Issue-side controller for the load/store reservation station. It drives the station's clearbusy/issueaddr read port and consumes its busyvec/ready vectors.
- Keeps a per-entry age queue of allocated entry indices and issues strictly in program order: only the oldest entry may issue, and only when it is ready.
- Registers the issued entry index into a one-stage launch register for the LDST execution pipe.
- Compacts the age queue on branch-miss (prmiss) using the station's surviving-busy vector.

Parameters:
- ENT_NUM, 4, number of station entries (age-queue depth).
- ENT_SEL, 2, entry index width; equals log2(ENT_NUM).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- we1  in  1  allocation slot 1 valid.
- waddr1  in  ENT_SEL  entry written by slot 1.
- we2  in  1  allocation slot 2 valid (younger than slot 1).
- waddr2  in  ENT_SEL  entry written by slot 2.
- busyvec  in  ENT_NUM  station busy bits.
- ready  in  ENT_NUM  station per-entry ready (busy and both operands valid).
- prmiss  in  1  branch mispredict this cycle.
- prsuccess  in  1  branch resolved correct this cycle.
- prbusyvec_next  in  ENT_NUM  busy bits that survive the mispredict.
- mem_stall  in  1  LDST pipe cannot accept an op this cycle.
- clearbusy  out  1  issue strobe to the station.
- issueaddr  out  ENT_SEL  entry being read/issued.
- ex_valid  out  1  launch register valid.
- ex_addr  out  ENT_SEL  launch register entry index.
- qcount  out  ENT_SEL+1  number of entries held in the age queue.
- ord_err  out  1  sticky consistency error.

Behaviour:
- State: age queue ord[0..ENT_NUM-1] of entry indices, ord[0] = oldest; count cnt (0..ENT_NUM); ex_valid, ex_addr, ord_err.
- Reset (reset=0, asynchronous): all ord slots=0, cnt=0, ex_valid=0, ex_addr=0, ord_err=0. As a result clearbusy=0, issueaddr=0, qcount=0. Reset mid-operation discards queue contents immediately.
- issueaddr = ord[0] (combinational). It is valid for the station's ex_src/pc/imm mux even when clearbusy=0.
- clearbusy = (cnt!=0) & ready[ord[0]] & ~mem_stall & ~prmiss (combinational, zero latency).
- Younger ready entries never bypass a non-ready head, so memory order is preserved.
- Normal cycle (no prmiss, no prsuccess), applied in this order:
  - If clearbusy, shift the queue down by one and decrement cnt.
  - If we1, append waddr1 at position cnt.
  - Then if we2, append waddr2 at the next position.
  - One issue plus two allocations in the same cycle is legal; the net count change is +1.
- prsuccess cycle (no prmiss): allocations are ignored, matching the station, which does not set busy then. Issue proceeds normally.
- prmiss cycle: no issue and allocations are ignored.
  - Next state keeps, in order, the slots i < cnt with prbusyvec_next[ord[i]]=1, packed toward ord[0].
  - cnt becomes the number kept. Vacated slots are written 0.
  - ex_valid is cleared.
- Launch register: ex_valid <= clearbusy and ex_addr <= issueaddr when clearbusy=1; otherwise ex_valid <= 0 and ex_addr holds. One-cycle latency from clearbusy to ex_valid.
- ord_err is set (sticky until reset) when any of these holds:
  - An allocation is attempted with no free slot, i.e. cnt + number of accepted allocations minus issue > ENT_NUM. Excess allocations are dropped.
  - cnt!=0 and busyvec[ord[0]]=0 outside a prmiss cycle.
  - we1 & we2 & (waddr1==waddr2) in a normal cycle.
- Empty (cnt=0): clearbusy=0. An allocation in that cycle is visible as head the next cycle, never the same cycle.
- Full (cnt=ENT_NUM): an issue in the same cycle frees exactly one slot, so one allocation is accepted without error.
- Width rule: qcount = cnt, zero-extended, never exceeding ENT_NUM.

Test Plan:
- Reset release, then we1=1 waddr1=2, we2=1 waddr2=0 -> next cycle qcount=2, issueaddr=2. With ready=4'b0101 and mem_stall=0, clearbusy=1. The following cycle ex_valid=1, ex_addr=2, issueaddr=0.
- Queue ord=[1,3], ready=4'b1000 (only the younger entry ready) -> clearbusy=0 every cycle until ready[1]=1. Then entry 1 issues first, entry 3 issues the next cycle.
- Queue ord=[0,1,2,3], prmiss=1, prbusyvec_next=4'b1010 -> clearbusy=0 that cycle. Next cycle qcount=2, ord=[1,3], ex_valid=0. Concurrent we1 is ignored.
- Full queue [3,2,1,0], head ready, we1=1 waddr1=3 (entry 3 issuing) -> qcount stays 4, ord=[2,1,0,3], ord_err=0. Repeat with head not ready -> ord_err=1, allocation dropped.
- Head ready with mem_stall=1 for 3 cycles -> clearbusy=0 and ex_valid=0 throughout. First cycle after mem_stall drops -> clearbusy=1.
- Assert reset low mid-issue with qcount=3 -> clearbusy, ex_valid, qcount and ord_err go to 0 before the next clock edge.
